// File: rtl/spi_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_regfile_pkg
// Description : Shared constants for the SPI register bank: register map
//               addresses, STATUS bit positions and the default ID byte.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_regfile_pkg;

  // Register map
  localparam logic [3:0] ADDR_ID     = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_EVCNT  = 4'd3;

  // STATUS bit positions (sticky, write-one-to-clear)
  localparam int ST_EVENT = 0;  // event_in seen
  localparam int ST_RO_WR = 1;  // write attempted to read-only ID
  localparam int ST_OVF   = 2;  // event counter overflow
  localparam int STATUS_W = 3;

  // Value returned at ADDR_ID unless overridden
  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/spi_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_det
// Description : One-bit rising-edge detector. The history flop resets to
//               RST_VAL so a level already high at reset release can be
//               masked (RST_VAL = 1) or reported (RST_VAL = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember the previous sample of the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/spi_regfile.sv
`default_nettype none
// ============================================================================
// Module      : spi_regfile
// Description : 16 x 8 register bank behind the SPI slave front end. Commits
//               each write strobe once (rising edge), snapshots read data on
//               each read strobe rising edge, keeps sticky W1C status, an
//               event counter and a transaction counter, and produces the
//               command-phase state_indication byte.
// Config      : SPI_REGFILE_EVCNT_EN - when defined, address 3 is the
//               saturating event counter and STATUS[2] (overflow) is live;
//               when undefined, address 3 is a general register and
//               STATUS[2] is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT,
  parameter int         EVCNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] address,
  input  logic [7:0] data_in,
  input  logic       write,
  input  logic       read,
  output logic [7:0] data_out,
  output logic [7:0] state_indication,
  input  logic       event_in,
  output logic [7:0] ctrl_out,
  output logic       irq
);

`ifdef SPI_REGFILE_EVCNT_EN
  localparam int GP_LO = 4;   // address 3 is the event counter
`else
  localparam int GP_LO = 3;   // address 3 is a general register
`endif

  // The counter is mapped onto an 8-bit register slot; other widths are not supported
  generate
    if (EVCNT_W != 8) begin : g_evcnt_w_check
      $error("spi_regfile: EVCNT_W must be 8");
    end
  endgenerate

  logic                w_wr_rise;
  logic                w_rd_rise;
  logic [7:0]          w_rd_data;
  logic                w_irq;

  logic [7:0]          ctrl_q, ctrl_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [7:0]          gp_q [GP_LO:15];
  logic [7:0]          gp_d [GP_LO:15];
`ifdef SPI_REGFILE_EVCNT_EN
  logic [EVCNT_W-1:0]  evcnt_q, evcnt_d;
`endif
  logic [3:0]          txn_cnt_q;
  logic [7:0]          data_out_q;
  logic [7:0]          state_ind_q;
  logic                irq_q;

  // History flops reset high so strobes held across reset release are ignored
  spi_edge_det #(.RST_VAL(1'b1)) u_wr_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (write),
    .rise_o (w_wr_rise)
  );

  spi_edge_det #(.RST_VAL(1'b1)) u_rd_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (read),
    .rise_o (w_rd_rise)
  );

  // Next-state for the register map: write effects first, then event sets so they win
  always_comb begin
    ctrl_d   = ctrl_q;
    status_d = status_q;
    gp_d     = gp_q;
`ifdef SPI_REGFILE_EVCNT_EN
    evcnt_d  = evcnt_q;
`endif
    if (w_wr_rise) begin
      case (address)
        ADDR_ID:     status_d[ST_RO_WR] = 1'b1;
        ADDR_CTRL:   ctrl_d = data_in;
        ADDR_STATUS: status_d = status_q & ~data_in[STATUS_W-1:0];
`ifdef SPI_REGFILE_EVCNT_EN
        ADDR_EVCNT:  evcnt_d = '0;
`endif
        default: begin
          for (int i = GP_LO; i < 16; i++) begin
            if (address == 4'(i)) begin
              gp_d[i] = data_in;
            end
          end
        end
      endcase
    end
    if (event_in) begin
      status_d[ST_EVENT] = 1'b1;
`ifdef SPI_REGFILE_EVCNT_EN
      // Saturate at all-ones; further events flag overflow instead
      if (evcnt_d == '1) begin
        status_d[ST_OVF] = 1'b1;
      end else begin
        evcnt_d = evcnt_d + 1'b1;
      end
`endif
    end
`ifndef SPI_REGFILE_EVCNT_EN
    status_d[ST_OVF] = 1'b0;
`endif
  end

  // Register map state; ID is a constant and needs no storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      status_q <= '0;
      for (int i = GP_LO; i < 16; i++) begin
        gp_q[i] <= '0;
      end
`ifdef SPI_REGFILE_EVCNT_EN
      evcnt_q  <= '0;
`endif
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      gp_q     <= gp_d;
`ifdef SPI_REGFILE_EVCNT_EN
      evcnt_q  <= evcnt_d;
`endif
    end
  end

  // Read mux over the current (pre-update) register contents
  always_comb begin
    w_rd_data = '0;
    case (address)
      ADDR_ID:     w_rd_data = ID_VALUE;
      ADDR_CTRL:   w_rd_data = ctrl_q;
      ADDR_STATUS: w_rd_data = {{(8 - STATUS_W){1'b0}}, status_q};
`ifdef SPI_REGFILE_EVCNT_EN
      ADDR_EVCNT:  w_rd_data = 8'(evcnt_q);
`endif
      default: begin
        for (int i = GP_LO; i < 16; i++) begin
          if (address == 4'(i)) begin
            w_rd_data = gp_q[i];
          end
        end
      end
    endcase
  end

  assign w_irq = |(status_q & ctrl_q[STATUS_W-1:0]);

  // Transaction counter, read snapshot and the one-cycle-lagged indication outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt_q   <= '0;
      data_out_q  <= '0;
      state_ind_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (w_wr_rise || w_rd_rise) begin
        txn_cnt_q <= txn_cnt_q + 4'd1;
      end
      if (w_rd_rise) begin
        data_out_q <= w_rd_data;
      end
      state_ind_q <= {w_irq, txn_cnt_q, status_q};
      irq_q       <= w_irq;
    end
  end

  assign data_out         = data_out_q;
  assign state_indication = state_ind_q;
  assign ctrl_out         = ctrl_q;
  assign irq              = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_regfile
// Description : Self-checking bench for spi_regfile. Read expectations are
//               queued as each read strobe is driven and popped when the
//               snapshot appears on data_out.
// Config      : SPI_REGFILE_EVCNT_EN selects the event-counter expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_regfile;

`ifdef SPI_REGFILE_EVCNT_EN
  localparam bit EVCNT_EN = 1'b1;
`else
  localparam bit EVCNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       write;
  logic       read;
  logic       event_in;
  logic [7:0] data_out;
  logic [7:0] state_indication;
  logic [7:0] ctrl_out;
  logic       irq;

  int         total;
  int         bad;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;
  logic [3:0] txn_model;

  spi_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .data_in          (data_in),
    .write            (write),
    .read             (read),
    .data_out         (data_out),
    .state_indication (state_indication),
    .event_in         (event_in),
    .ctrl_out         (ctrl_out),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    write   = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    txn_model = txn_model + 4'd1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    read      = 1'b0;
    txn_model = txn_model + 4'd1;
  endtask

  task automatic pulse_events(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      event_in = 1'b1;
      @(negedge clk);
      event_in = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; address = 4'd4; data_in = 8'h3C; write = 1'b1; read = 1'b0; event_in = 1'b0;
    txn_model = 4'd0;
    idle(3);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out: got=%h want=00", data_out); end
    total++; if (state_indication !== 8'h00) begin bad++; $display("FAIL rst_state_ind: got=%h want=00", state_indication); end
    total++; if (ctrl_out !== 8'h00) begin bad++; $display("FAIL rst_ctrl_out: got=%h want=00", ctrl_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got=%b want=0", irq); end
    rst = 1'b0;
    idle(3);
    write = 1'b0;
    idle(1);
    total++; if (state_indication !== 8'h00) begin bad++; $display("FAIL rst_held_write_txn: got=%h want=00", state_indication); end
    do_read(4'd4, 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL rst_held_write_reg4: got=%h want=%h", data_out, exp_v); end
    idle(2);
    total++; if (state_indication !== {1'b0, txn_model, 3'b000}) begin bad++; $display("FAIL rst_first_txn: got=%h want=%h", state_indication, {1'b0, txn_model, 3'b000}); end
  endtask

  task automatic test_hold_write;
    @(negedge clk);
    address = 4'd1; data_in = 8'h07; write = 1'b1;
    idle(20);
    write = 1'b0;
    txn_model = txn_model + 4'd1;
    idle(2);
    total++; if (ctrl_out !== 8'h07) begin bad++; $display("FAIL hold_ctrl_out: got=%h want=07", ctrl_out); end
    total++; if (state_indication[6:3] !== txn_model) begin bad++; $display("FAIL hold_txn_once: got=%h want=%h", state_indication[6:3], txn_model); end
  endtask

  task automatic test_id_protect;
    do_read(4'd0, 8'hA5);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL id_read: got=%h want=%h", data_out, exp_v); end
    do_write(4'd0, 8'hFF);
    do_read(4'd0, 8'hA5);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL id_after_write: got=%h want=%h", data_out, exp_v); end
    do_read(4'd2, 8'h02);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL ro_write_status: got=%h want=%h", data_out, exp_v); end
    idle(2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ro_write_irq: got=%b want=1", irq); end
    total++; if (state_indication !== {1'b1, txn_model, 3'b010}) begin bad++; $display("FAIL ro_state_ind: got=%h want=%h", state_indication, {1'b1, txn_model, 3'b010}); end
    do_write(4'd2, 8'h02);
    do_read(4'd2, 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL w1c_ro_bit: got=%h want=%h", data_out, exp_v); end
    idle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_ro_irq: got=%b want=0", irq); end
  endtask

  task automatic test_events;
    do_write(4'd1, 8'h05);
    pulse_events(300);
    idle(2);
    do_read(4'd3, EVCNT_EN ? 8'hFF : 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL evcnt_saturate: got=%h want=%h", data_out, exp_v); end
    do_read(4'd2, EVCNT_EN ? 8'h05 : 8'h01);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL event_status: got=%h want=%h", data_out, exp_v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL event_irq: got=%b want=1", irq); end
    do_write(4'd2, 8'h05);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag: got=%b want=1", irq); end
    idle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared: got=%b want=0", irq); end
    do_read(4'd2, 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL w1c_all: got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    address = 4'd2; data_in = 8'h01; write = 1'b1; event_in = 1'b1;
    @(negedge clk);
    write = 1'b0; event_in = 1'b0;
    txn_model = txn_model + 4'd1;
    do_read(4'd2, 8'h01);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL set_beats_w1c: got=%h want=%h", data_out, exp_v); end
    @(negedge clk);
    address = 4'd3; data_in = 8'h77; write = 1'b1; event_in = 1'b1;
    @(negedge clk);
    write = 1'b0; event_in = 1'b0;
    txn_model = txn_model + 4'd1;
    do_read(4'd3, EVCNT_EN ? 8'h01 : 8'h77);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL event_with_evcnt_write: got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_addr3;
    do_write(4'd3, 8'h5A);
    do_read(4'd3, EVCNT_EN ? 8'h00 : 8'h5A);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL addr3_write: got=%h want=%h", data_out, exp_v); end
    pulse_events(3);
    do_read(4'd3, EVCNT_EN ? 8'h03 : 8'h5A);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL addr3_after_events: got=%h want=%h", data_out, exp_v); end
    do_read(4'd2, 8'h01);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL status_no_ovf: got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_back_to_back;
    do_write(4'd5, 8'h11);
    @(negedge clk);
    address = 4'd5; data_in = 8'h22; write = 1'b1; read = 1'b1;
    exp_q.push_back(8'h11);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    txn_model = txn_model + 4'd1;
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL wr_rd_pre_write: got=%h want=%h", data_out, exp_v); end
    do_read(4'd5, 8'h22);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL wr_rd_post_write: got=%h want=%h", data_out, exp_v); end
    do_read(4'd1, 8'h05);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL ctrl_readback: got=%h want=%h", data_out, exp_v); end
    idle(2);
    total++; if (state_indication[6:3] !== txn_model) begin bad++; $display("FAIL txn_count: got=%h want=%h", state_indication[6:3], txn_model); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    address = 4'd6; data_in = 8'h99; write = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++; if (ctrl_out !== 8'h00) begin bad++; $display("FAIL async_rst_ctrl: got=%h want=00", ctrl_out); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL async_rst_data_out: got=%h want=00", data_out); end
    total++; if (state_indication !== 8'h00) begin bad++; $display("FAIL async_rst_state_ind: got=%h want=00", state_indication); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq: got=%b want=0", irq); end
    txn_model = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write = 1'b0;
    idle(1);
    do_read(4'd6, 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL mid_rst_no_write: got=%h want=%h", data_out, exp_v); end
    do_read(4'd1, 8'h00);
    exp_v = exp_q.pop_front();
    total++; if (data_out !== exp_v) begin bad++; $display("FAIL mid_rst_ctrl: got=%h want=%h", data_out, exp_v); end
    idle(2);
    total++; if (state_indication[6:3] !== txn_model) begin bad++; $display("FAIL mid_rst_txn: got=%h want=%h", state_indication[6:3], txn_model); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_hold_write;
    test_id_protect;
    test_events;
    test_simultaneous;
    test_addr3;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
